// File: rtl/cmd_sequencer.sv
// Command FIFO and issue sequencer in front of the ALU breadboard.
// Optional CMD_SEQ_ISSUE_CNT_EN adds a saturating issue_cnt[15:0] output.
module cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_opcode,
    input  logic [W-1:0]             in_operand,
    output logic [3:0]               opcode,
    output logic [W-1:0]             operand,
    output logic                     halted,
    output logic                     standby,
    output logic                     err,
`ifdef CMD_SEQ_ISSUE_CNT_EN
    output logic [15:0]              issue_cnt,
`endif
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    localparam logic [3:0] OP_NOOP     = 4'b0000;
    localparam logic [3:0] OP_STANDBY  = 4'b0100;
    localparam logic [3:0] OP_ATTACK   = 4'b0101;
    localparam logic [3:0] OP_GOTO     = 4'b0110;
    localparam logic [3:0] OP_TARGET   = 4'b0111;
    localparam logic [3:0] OP_RANK     = 4'b1000;
    localparam logic [3:0] OP_BATTERY  = 4'b1001;
    localparam logic [3:0] OP_ATLOC    = 4'b1010;
    localparam logic [3:0] OP_RESET    = 4'b1100;
    localparam logic [3:0] OP_SHUTDOWN = 4'b1101;

    localparam logic [1:0] S_ISSUE = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    logic [3+W:0]   mem [DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic [1:0]     state;
    logic [W-1:0]   cnt;

    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic           flush;
    logic           legal;
    logic [3:0]     head_op;
    logic [W-1:0]   head_arg;

    function automatic logic is_legal(input logic [3:0] op);
        case (op)
            OP_NOOP, OP_STANDBY, OP_ATTACK, OP_GOTO, OP_TARGET,
            OP_RANK, OP_BATTERY, OP_ATLOC, OP_RESET, OP_SHUTDOWN:
                is_legal = 1'b1;
            default:
                is_legal = 1'b0;
        endcase
    endfunction

    assign full     = (level == FULL_LVL);
    assign empty    = (level == '0);
    assign in_ready = !full && (state != S_HALT);
    assign push     = in_valid && in_ready;
    assign pop      = (state == S_ISSUE) && !empty;
    assign head_op  = mem[rptr][3+W:W];
    assign head_arg = mem[rptr][W-1:0];
    assign legal    = is_legal(head_op);
    // A popped RESET discards every entry still queued behind it
    assign flush    = pop && (head_op == OP_RESET);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= {in_opcode, in_operand};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            level <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (flush) begin
                rptr <= wptr;
                level <= {{AW{1'b0}}, push};
            end else begin
                if (pop) begin
                    rptr <= rptr + 1'b1;
                end
                if (push && !pop) begin
                    level <= level + 1'b1;
                end else if (pop && !push) begin
                    level <= level - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_ISSUE;
            cnt <= '0;
            opcode <= OP_NOOP;
            operand <= '0;
            halted <= 1'b0;
            standby <= 1'b0;
            err <= 1'b0;
        end else begin
            opcode <= OP_NOOP;
            operand <= '0;
            case (state)
                S_ISSUE: begin
                    if (pop) begin
                        if (legal) begin
                            opcode <= head_op;
                            operand <= head_arg;
                        end else begin
                            err <= 1'b1;
                        end
                        if (head_op == OP_STANDBY && head_arg != '0) begin
                            cnt <= head_arg;
                            state <= S_WAIT;
                            standby <= 1'b1;
                        end
                        if (head_op == OP_SHUTDOWN) begin
                            state <= S_HALT;
                            halted <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == W'(1)) begin
                        state <= S_ISSUE;
                        standby <= 1'b0;
                    end
                end
                default: begin
                    state <= S_HALT;
                end
            endcase
        end
    end

`ifdef CMD_SEQ_ISSUE_CNT_EN
    // Counts real commands reaching the breadboard; padding and squashed codes excluded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt <= '0;
        end else if (pop && legal && head_op != OP_NOOP
                     && issue_cnt != 16'hFFFF) begin
            issue_cnt <= issue_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed bench for cmd_sequencer.
// Issue-counter checks run only when CMD_SEQ_ISSUE_CNT_EN is defined.
module tb_cmd_sequencer;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_opcode;
    logic [1:0] in_operand;
    logic [3:0] opcode;
    logic [1:0] operand;
    logic       halted;
    logic       standby;
    logic       err;
    logic [2:0] level;
`ifdef CMD_SEQ_ISSUE_CNT_EN
    logic [15:0] issue_cnt;
`endif

    int total = 0;
    int bad = 0;

    cmd_sequencer #(.DEPTH(4), .W(2)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_opcode(in_opcode),
        .in_operand(in_operand),
        .opcode(opcode),
        .operand(operand),
        .halted(halted),
        .standby(standby),
        .err(err),
`ifdef CMD_SEQ_ISSUE_CNT_EN
        .issue_cnt(issue_cnt),
`endif
        .level(level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op,
                         input logic [1:0] arg);
        in_valid = v;
        in_opcode = op;
        in_operand = arg;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 2'd0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_opcode = 4'h0;
        in_operand = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state after 3 idle cycles
        repeat (3) idle();
        chk("rst_op", opcode, 4'h0);
        chk("rst_arg", operand, 2'd0);
        chk("rst_rdy", in_ready, 1'b1);
        chk("rst_lvl", level, 3'd0);
        chk("rst_flags", {halted, standby, err}, 3'b000);

        // back-to-back ATTACK, GOTO, BATTERY
        drive(1'b1, 4'h5, 2'd1);
        chk("s2_nobypass", opcode, 4'h0);
        chk("s2_lvl1", level, 3'd1);
        drive(1'b1, 4'h6, 2'd2);
        chk("s2_attack", {opcode, operand}, {4'h5, 2'd1});
        drive(1'b1, 4'h9, 2'd3);
        chk("s2_goto", {opcode, operand}, {4'h6, 2'd2});
        idle();
        chk("s2_battery", {opcode, operand}, {4'h9, 2'd3});
        chk("s2_lvl0", level, 3'd0);
        idle();
        chk("s2_pad", {opcode, operand}, {4'h0, 2'd0});

        // STANDBY/3 then ATTACK/1
        drive(1'b1, 4'h4, 2'd3);
        drive(1'b1, 4'h5, 2'd1);
        chk("s3_stby", {opcode, operand, standby}, {4'h4, 2'd3, 1'b1});
        idle();
        chk("s3_w1", {opcode, standby}, {4'h0, 1'b1});
        idle();
        chk("s3_w2", {opcode, standby}, {4'h0, 1'b1});
        idle();
        chk("s3_w3", opcode, 4'h0);
        idle();
        chk("s3_attack", {opcode, operand, standby}, {4'h5, 2'd1, 1'b0});

        // STANDBY/0 falls straight through
        drive(1'b1, 4'h4, 2'd0);
        drive(1'b1, 4'h6, 2'd2);
        chk("s3_stby0", {opcode, standby}, {4'h4, 1'b0});
        idle();
        chk("s3_goto", {opcode, operand}, {4'h6, 2'd2});

        // fill to DEPTH during WAIT
        drive(1'b1, 4'h4, 2'd3);
        drive(1'b1, 4'h5, 2'd0);
        chk("s4_stby", opcode, 4'h4);
        drive(1'b1, 4'h6, 2'd1);
        drive(1'b1, 4'h7, 2'd2);
        drive(1'b1, 4'h8, 2'd3);
        chk("s4_full_lvl", level, 3'd4);
        chk("s4_full_rdy", in_ready, 1'b0);
        drive(1'b1, 4'hA, 2'd1);
        chk("s4_holdoff", level, 3'd3);
        chk("s4_x1", {opcode, operand}, {4'h5, 2'd0});
        idle();
        idle();
        idle();
        chk("s4_x4", {opcode, operand}, {4'h8, 2'd3});
        chk("s4_drain", level, 3'd0);

        // RESET flushes queued entries, keeps same-cycle push
        drive(1'b1, 4'h4, 2'd2);
        drive(1'b1, 4'h8, 2'd0);
        drive(1'b1, 4'hC, 2'd0);
        drive(1'b1, 4'h9, 2'd1);
        drive(1'b1, 4'hA, 2'd2);
        chk("s4_rank", opcode, 4'h8);
        drive(1'b1, 4'h7, 2'd3);
        chk("s4_reset", opcode, 4'hC);
        chk("s4_flush_lvl", level, 3'd1);
        idle();
        chk("s4_target", {opcode, operand}, {4'h7, 2'd3});
        chk("s4_lvl0", level, 3'd0);
        idle();
        chk("s4_noop", opcode, 4'h0);

        // illegal, SHUTDOWN, ATLOC
        drive(1'b1, 4'hF, 2'd1);
        drive(1'b1, 4'hD, 2'd0);
        chk("s5_illegal", {opcode, operand, err}, {4'h0, 2'd0, 1'b1});
        drive(1'b1, 4'hA, 2'd2);
        chk("s5_shutdown", {opcode, halted}, {4'hD, 1'b1});
        chk("s5_rdy", in_ready, 1'b0);
        idle();
        chk("s5_halt1", {opcode, halted, err}, {4'h0, 1'b1, 1'b1});
        chk("s5_frozen", level, 3'd1);
        drive(1'b1, 4'h5, 2'd1);
        idle();
        chk("s5_halt2", {opcode, operand, in_ready}, {4'h0, 2'd0, 1'b0});

        // async reset from HALT
        #3;
        rst = 1'b1;
        #1;
        chk("s5_rst_op", {opcode, operand}, {4'h0, 2'd0});
        chk("s5_rst_flags", {halted, standby, err}, 3'b000);
        chk("s5_rst_lvl", level, 3'd0);
        chk("s5_rst_rdy", in_ready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;

`ifdef CMD_SEQ_ISSUE_CNT_EN
        drive(1'b1, 4'h5, 2'd1);
        drive(1'b1, 4'h6, 2'd2);
        drive(1'b1, 4'h9, 2'd3);
        idle();
        idle();
        chk("s6_cnt3", issue_cnt, 16'd3);
        force dut.issue_cnt = 16'hFFFE;
        idle();
        release dut.issue_cnt;
        drive(1'b1, 4'h5, 2'd1);
        drive(1'b1, 4'h6, 2'd2);
        drive(1'b1, 4'h9, 2'd3);
        idle();
        idle();
        chk("s6_sat", issue_cnt, 16'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
